// File: rtl/tt_sel_seq.sv
// -----------------------------------------------------------------------------
// tt_sel_seq
//
// Purpose:
//   Drives the three design-select control pins of the top-level controller
//   (selector reset, selector increment, design enable) from a simple request
//   interface. A request carrying an address N produces the waveform:
//     sel_rst_n low for T_RST cycles,
//     a T_PULSE-cycle gap with sel_rst_n high,
//     N increment pulses (T_PULSE high, T_PULSE low each),
//     then ena is driven to the requested level.
//   An abort input cancels any in-flight sequence and parks the pins in a
//   safe state (selector held in reset, increment low, design disabled).
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   req_valid      request present
//   req_ready      request can be accepted (high only while idle)
//   req_addr       target design address = number of increment pulses
//   req_ena        ena level to apply once the address is reached
//   abort          synchronous abort of an in-flight sequence
//   busy           high whenever a sequence is in progress
//   done           one-cycle pulse when a sequence completes
//   cur_addr       address applied by the last completed sequence
//   cur_valid      cur_addr reflects the selector state
//   ctrl_sel_rst_n selector reset pin, active low (registered)
//   ctrl_sel_inc   selector increment strobe pin (registered)
//   ctrl_ena       design enable pin (registered)
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE; a requester that
// raises req_valid while busy must hold it (with stable req_addr/req_ena)
// until that transfer edge. req_ready does not depend on req_valid.
// -----------------------------------------------------------------------------
module tt_sel_seq #(
    parameter int ADDR_W  = 10,
    parameter int T_RST   = 4,   // 1..255
    parameter int T_PULSE = 2    // 1..255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RST    = 3'd1,
        S_GAP    = 3'd2,
        S_INC_HI = 3'd3,
        S_INC_LO = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    // Timers are loaded with (duration - 1) and the phase ends on the edge
    // where the timer reads zero, so each phase lasts exactly its duration.
    localparam logic [7:0] RST_LOAD   = 8'(T_RST - 1);
    localparam logic [7:0] PULSE_LOAD = 8'(T_PULSE - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    state_t            state;
    logic [7:0]        timer;
    logic [ADDR_W-1:0] cnt;      // increments still to issue
    logic [ADDR_W-1:0] addr_q;   // address of the request in flight
    logic              ena_q;    // ena level of the request in flight

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            timer          <= '0;
            cnt            <= '0;
            addr_q         <= '0;
            ena_q          <= 1'b0;
            done           <= 1'b0;
            cur_addr       <= '0;
            cur_valid      <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Abort wins over every sequencing step, including FIN, so an
            // aborted sequence never reports completion. It is ignored in
            // IDLE, which also makes a same-edge request win over abort.
            if (abort && (state != S_IDLE)) begin
                state          <= S_IDLE;
                timer          <= '0;
                ctrl_sel_inc   <= 1'b0;
                ctrl_ena       <= 1'b0;
                ctrl_sel_rst_n <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Pins keep their last values while idle.
                        if (req_valid) begin
                            cnt            <= req_addr;
                            addr_q         <= req_addr;
                            ena_q          <= req_ena;
                            ctrl_ena       <= 1'b0;
                            ctrl_sel_rst_n <= 1'b0;
                            cur_valid      <= 1'b0;
                            timer          <= RST_LOAD;
                            state          <= S_RST;
                        end
                    end

                    S_RST: begin
                        if (timer == 8'd0) begin
                            ctrl_sel_rst_n <= 1'b1;
                            timer          <= PULSE_LOAD;
                            state          <= S_GAP;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end

                    S_GAP: begin
                        if (timer == 8'd0) begin
                            timer <= PULSE_LOAD;
                            if (cnt == '0) begin
                                state <= S_FIN;
                            end else begin
                                ctrl_sel_inc <= 1'b1;
                                state        <= S_INC_HI;
                            end
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end

                    S_INC_HI: begin
                        if (timer == 8'd0) begin
                            ctrl_sel_inc <= 1'b0;
                            timer        <= PULSE_LOAD;
                            state        <= S_INC_LO;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end

                    S_INC_LO: begin
                        if (timer == 8'd0) begin
                            cnt   <= cnt - CNT_ONE;
                            timer <= PULSE_LOAD;
                            // Test the pre-decrement value against one so the
                            // decision never depends on a wrapped counter.
                            if (cnt == CNT_ONE) begin
                                state <= S_FIN;
                            end else begin
                                ctrl_sel_inc <= 1'b1;
                                state        <= S_INC_HI;
                            end
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end

                    S_FIN: begin
                        ctrl_ena  <= ena_q;
                        done      <= 1'b1;
                        cur_addr  <= addr_q;
                        cur_valid <= 1'b1;
                        state     <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_sel_seq.sv
// -----------------------------------------------------------------------------
// tb_tt_sel_seq
//
// Self-checking bench for tt_sel_seq. The main instance (ADDR_W=10) is driven
// through a request driver; each accepted request pushes {ena, addr} onto an
// expected queue, and a negedge monitor pops and checks it on every done
// pulse (address, ena, latency, pulse count and widths, reset-low length).
// A second instance (ADDR_W=4) exercises the maximum address.
// -----------------------------------------------------------------------------
module tb_tt_sel_seq;

    localparam int ADDR_W  = 10;
    localparam int M_W     = 4;
    localparam int T_RST   = 4;
    localparam int T_PULSE = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT ----------------
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic              req_ena   = 1'b0;
    logic              abort     = 1'b0;
    logic              busy, done, cur_valid;
    logic [ADDR_W-1:0] cur_addr;
    logic              ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
    logic [2:0]        state_dbg;

    tt_sel_seq #(.ADDR_W(ADDR_W), .T_RST(T_RST), .T_PULSE(T_PULSE)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_ena(req_ena), .abort(abort),
        .busy(busy), .done(done), .cur_addr(cur_addr), .cur_valid(cur_valid),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
        .ctrl_ena(ctrl_ena), .state_dbg(state_dbg)
    );

    // ---------------- max-address DUT ----------------
    logic           m_req_valid = 1'b0;
    logic           m_req_ready;
    logic [M_W-1:0] m_req_addr  = '0;
    logic           m_req_ena   = 1'b0;
    logic           m_abort     = 1'b0;
    logic           m_busy, m_done, m_cur_valid;
    logic [M_W-1:0] m_cur_addr;
    logic           m_sel_rst_n, m_sel_inc, m_ena;
    logic [2:0]     m_state_dbg;

    tt_sel_seq #(.ADDR_W(M_W), .T_RST(T_RST), .T_PULSE(T_PULSE)) u_max (
        .clk(clk), .rst(rst),
        .req_valid(m_req_valid), .req_ready(m_req_ready),
        .req_addr(m_req_addr), .req_ena(m_req_ena), .abort(m_abort),
        .busy(m_busy), .done(m_done), .cur_addr(m_cur_addr), .cur_valid(m_cur_valid),
        .ctrl_sel_rst_n(m_sel_rst_n), .ctrl_sel_inc(m_sel_inc),
        .ctrl_ena(m_ena), .state_dbg(m_state_dbg)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_latency(input int a);
        return T_RST + T_PULSE * (2 * a + 1) + 1;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [ADDR_W:0]   exp_q[$];   // {ena, addr}
    logic [ADDR_W:0]   exp_e;
    logic [ADDR_W-1:0] exp_a;
    logic              exp_en;
    logic prev_inc  = 1'b0;
    logic prev_done = 1'b0;
    bit   acc_seen  = 1'b0;
    int   inc_rises = 0, hi_len = 0, lo_len = 0, rst_low = 0;
    int   acc_cyc = 0, last_done_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_inc  = 1'b0;
            prev_done = 1'b0;
            acc_seen  = 1'b0;
        end else begin
            // First cycle after an accepting edge: pins forced to the
            // start-of-sequence state.
            if (acc_seen) begin
                acc_seen = 1'b0;
                check_eq("acc_ena_low", ctrl_ena, 0);
                check_eq("acc_rst_n_low", ctrl_sel_rst_n, 0);
                check_eq("acc_busy", busy, 1);
                check_eq("acc_cur_valid", cur_valid, 0);
            end
            if (busy && !ctrl_sel_rst_n) rst_low++;
            if (ctrl_sel_inc) begin
                if (!prev_inc) begin
                    inc_rises++;
                    if (inc_rises > 1) check_eq("inc_lo_width", lo_len, T_PULSE);
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev_inc) begin
                    if (busy) check_eq("inc_hi_width", hi_len, T_PULSE);
                    lo_len = 0;
                end
                lo_len++;
            end
            if (done) begin
                check_eq("done_1cyc", prev_done, 0);
                if (exp_q.size() == 0) begin
                    check_eq("done_unexpected", 1, 0);
                end else begin
                    exp_e  = exp_q.pop_front();
                    exp_a  = exp_e[ADDR_W-1:0];
                    exp_en = exp_e[ADDR_W];
                    check_eq("cur_addr", cur_addr, exp_a);
                    check_eq("ctrl_ena", ctrl_ena, exp_en);
                    check_eq("cur_valid", cur_valid, 1);
                    check_eq("done_busy", busy, 0);
                    check_eq("inc_pulses", inc_rises, exp_a);
                    check_eq("rst_low_len", rst_low, T_RST);
                    check_eq("latency", cyc - acc_cyc, exp_latency(int'(exp_a)));
                end
                last_done_cyc = cyc;
            end
            if (req_valid && req_ready) begin
                acc_cyc   = cyc + 1;
                acc_seen  = 1'b1;
                inc_rises = 0;
                rst_low   = 0;
            end
            prev_inc  = ctrl_sel_inc;
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. Holds req_valid until accepted; returns the
    // cycle index of the accepting edge.
    task automatic send(input logic [ADDR_W-1:0] a, input logic en,
                        input bit expect_done, output int acc);
        req_addr  = a;
        req_ena   = en;
        req_valid = 1'b1;
        acc       = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc + 1;
                if (expect_done) exp_q.push_back({en, a});
                break;
            end
        end
        if (acc < 0) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int acc, acc2, n, m_acc;
        bit p, got;
        logic [ADDR_W-1:0] ra;
        logic re;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_sel_rst_n", ctrl_sel_rst_n, 0);
        check_eq("rst_sel_inc", ctrl_sel_inc, 0);
        check_eq("rst_ena", ctrl_ena, 0);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cur_valid", cur_valid, 0);
        check_eq("rst_cur_addr", cur_addr, 0);
        check_eq("rst_m_ready", m_req_ready, 1);
        wait_cycles(2);

        // addr=3, ena=1 and addr=0, ena=1
        send(10'd3, 1'b1, 1'b1, acc);
        wait_idle(100);
        send(10'd0, 1'b1, 1'b1, acc);
        wait_idle(100);

        // Abort while idle has no effect
        abort = 1'b1;
        wait_cycles(3);
        abort = 1'b0;
        @(negedge clk);
        check_eq("idle_abort_ena", ctrl_ena, 1);
        check_eq("idle_abort_cur_valid", cur_valid, 1);
        check_eq("idle_abort_rst_n", ctrl_sel_rst_n, 1);
        check_eq("idle_abort_busy", busy, 0);
        wait_cycles(1);

        // Abort and request on the same idle edge: request wins
        req_addr  = 10'd1;
        req_ena   = 1'b0;
        req_valid = 1'b1;
        abort     = 1'b1;
        exp_q.push_back({1'b0, 10'd1});
        wait_cycles(1);
        req_valid = 1'b0;
        abort     = 1'b0;
        wait_idle(100);

        // Abort during the 2nd INC_HI of addr=5
        send(10'd5, 1'b1, 1'b0, acc);
        n = 0;
        p = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ctrl_sel_inc && !p) n++;
            p = ctrl_sel_inc;
            if (n == 2) break;
        end
        check_eq("abort_reach_inc2", n, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_inc", ctrl_sel_inc, 0);
        check_eq("abort_ena", ctrl_ena, 0);
        check_eq("abort_rst_n", ctrl_sel_rst_n, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_cur_valid", cur_valid, 0);
        wait_cycles(40);
        check_eq("abort_cur_valid_late", cur_valid, 0);

        // Back-to-back with req_valid held: addr=2 then addr=1
        send(10'd2, 1'b1, 1'b1, acc);
        send(10'd1, 1'b1, 1'b1, acc2);
        check_eq("b2b_accept_edge", acc2, last_done_cyc + 1);
        wait_idle(100);
        check_eq("b2b_final_addr", cur_addr, 1);

        // Random requests
        for (int k = 0; k < 4; k++) begin
            ra = ADDR_W'($urandom_range(0, 12));
            re = 1'($urandom_range(0, 1));
            send(ra, re, 1'b1, acc);
            wait_idle(200);
        end

        // Maximum address on the 4-bit instance
        m_req_addr  = 4'd15;
        m_req_ena   = 1'b0;
        m_req_valid = 1'b1;
        @(negedge clk);
        check_eq("max_ready", m_req_ready, 1);
        m_acc = cyc + 1;
        @(posedge clk);
        #1 m_req_valid = 1'b0;
        n   = 0;
        p   = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_sel_inc && !p) n++;
            p = m_sel_inc;
            if (m_done) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("max_done_seen", got, 1);
        check_eq("max_latency", cyc - m_acc, exp_latency(15));
        check_eq("max_pulses", n, 15);
        check_eq("max_ena", m_ena, 0);
        check_eq("max_cur_addr", m_cur_addr, 15);
        check_eq("max_cur_valid", m_cur_valid, 1);
        wait_cycles(2);

        // Asynchronous reset mid-sequence
        send(10'd6, 1'b1, 1'b0, acc);
        wait_cycles(10);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_ready", req_ready, 1);
        check_eq("arst_rst_n", ctrl_sel_rst_n, 0);
        check_eq("arst_inc", ctrl_sel_inc, 0);
        check_eq("arst_ena", ctrl_ena, 0);
        check_eq("arst_cur_addr", cur_addr, 0);
        check_eq("arst_cur_valid", cur_valid, 0);
        check_eq("arst_m_cur_addr", m_cur_addr, 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(5);
        check_eq("end_busy", busy, 0);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
